mem_ctrl: RTL
=============

// Module: mem_ctrl
// PURPOSE
//  Sole owner of the byte-wide external RAM/IO port. Serves three clients by fixed-priority arbitration:
//  - a one-entry write buffer fed by the D-cache;
//  - D-cache reads (length 1/2/4, signed/unsigned);
//  - I-cache word reads.
//  It serialises every access into byte beats and assembles or sign-extends read results.
// PARAMETERS
//  ADDR_W   32  address width of client and RAM ports
//  IO_BIT   17  address bit selecting IO space (IO writes honour io_full)
// PORTS
//  clock     in   1       single clock, rising edge
//  reset     in   1       asynchronous, active-low
//  i_read    in   1       I-cache read request, held until i_ready
//  i_addr    in   ADDR_W  I-cache word address
//  i_busy    out  1       I request accepted and not yet retired
//  i_ready   out  1       one-cycle pulse, i_data valid
//  i_data    out  32      assembled word
//  d_read    in   1       D-cache read request, held until d_ready
//  d_length  in   3       1/2/4 bytes
//  d_signed  in   1       sign-extend sub-word result
//  d_addr    in   ADDR_W  D read address
//  d_busy    out  1       D request accepted and not yet retired
//  d_ready   out  1       one-cycle pulse, d_data valid
//  d_data    out  32      extended result
//  b_write   in   1       one-cycle push into write buffer
//  b_length  in   3       1/2/4 bytes
//  b_addr    in   ADDR_W  write address
//  b_data    in   32      write data, little-endian, low bytes used
//  b_busy    out  1       buffer entry valid (not yet drained)
//  mem_din   in   8       RAM read byte, valid 1 cycle after its address
//  io_full   in   1       IO sink full; stalls IO-space write beats
//  mem_dout  out  8       write byte
//  mem_a     out  ADDR_W  byte address
//  mem_wr    out  1       1 = write beat
// BEHAVIOUR
//  Reset (async, active-low): all outputs 0; state IDLE; buffer empty.
//  - Any in-flight access is abandoned. Clients re-issue after release.
//  Write buffer:
//  - b_write with buffer empty latches length/addr/data at the edge.
//  - b_busy=1 from the next cycle until the cycle after the last beat.
//  - b_write while b_busy=1 is a protocol violation: the push is ignored and the bench flags it.
//  - A push is accepted in the same cycle b_busy falls.
//  Arbitration (IDLE only, fixed priority): buffer drain > d_read > i_read.
//  - A loser keeps its request held; its busy stays 0.
//  - Buffer-first gives program order: a push at cycle t beats a D read first visible at t+1.
//  States: IDLE -> RD | WR; RD -> DONE -> IDLE; WR -> IDLE.
//  - Mem outputs are registered. Accepting at edge t gives the first beat on mem_a at t+1.
//  RD (len L; I-cache L=4 unsigned; illegal lengths act as 4):
//  - Cycle k = 0..L-1: mem_a = addr+k, mem_wr=0.
//  - Byte k is captured from mem_din at cycle k+1.
//  - At cycle L the last byte is captured, then DONE.
//  - In DONE, x_ready=1 for one cycle with data extended per length/signed.
//  - x_busy=1 from t+1 through the DONE cycle, so the client cannot re-issue during ready.
//  - Latency accept->ready is L+2 cycles (word = 6).
//  WR: beat k = 0..L-1 drives mem_a=addr+k, mem_dout=b_data[8k+7:8k], mem_wr=1.
//  - If addr[IO_BIT]=1 and io_full=1: hold the beat with mem_wr=0, counter frozen; resume when io_full=0.
//  - After the last beat: buffer cleared, IDLE.
//  Outside beats: mem_wr=0, mem_a=0, mem_dout=0.
//  Address increment wraps modulo 2^ADDR_W.
//  Requests dropped mid-transaction are still completed; the ready pulse is discarded by the client.
// STRUCTURE
//  Shared package/define: length codes (1/2/4), IO_BIT, state encoding IDLE/RD/WR/DONE, byte/word bus macros.
//  Sub-module mem_wbuf: one-entry write buffer (latch, b_busy, drain-done clear).
//  Arbiter, beat counter and assembler stay in mem_ctrl.
// TESTING
//  1. i_read @0x100, RAM 11 22 33 44 -> i_busy from t+1; mem_a 0x100..0x103; i_ready at t+6, i_data=0x44332211.
//  2. d_read len1 @0x103 byte 0x80: signed -> 0xFFFFFF80; unsigned -> 0x00000080. Len2 signed 0x8001 -> 0xFFFF8001.
//  3. d_read and i_read both rise in IDLE -> D served first; I accepted the cycle after d_ready; two distinct results.
//  4. b_write len4 @0x200 data 0xA1B2C3D4 -> mem_wr 4 cycles, bytes D4 C3 B2 A1 @0x200..0x203. A d_read asserted while b_busy waits until the drain finishes.
//  5. b_write len1 @0x30000 data 0x5A, io_full high 3 cycles -> mem_wr=0 for 3 cycles, then one beat 0x5A; b_busy clears next cycle.
//  6. reset low during beat 2 of a word read -> all outputs 0 immediately; after release, held i_read re-accepted and completes correctly.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared length codes, bus types, FSM states and helpers for mem_ctrl.
package mem_ctrl_pkg;
  localparam int IO_BIT_DEF = 17;
  localparam logic [2:0] LEN_B = 3'd1;
  localparam logic [2:0] LEN_H = 3'd2;
  localparam logic [2:0] LEN_W = 3'd4;
  typedef logic [7:0] byte_t;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  function automatic logic [2:0] eff_len(input logic [2:0] len);
    return (len == LEN_B || len == LEN_H) ? len : LEN_W;
  endfunction
  // Read bytes shift in from the top, so a sub-word result is left-justified in acc.
  function automatic word_t extend(input word_t acc, input logic [2:0] len, input logic sgn);
    return len == LEN_B ? {{24{sgn & acc[31]}}, acc[31:24]} :
           len == LEN_H ? {{16{sgn & acc[31]}}, acc[31:16]} : acc;
  endfunction
endpackage

// File: rtl/mem_wbuf.sv
// mem_wbuf: one-entry write buffer; latches a push when empty, cleared when its drain finishes.
// Ports: clock/reset (async, active-low); b_write/b_length/b_addr/b_data push side;
// clear ends the entry after its last beat; b_busy entry valid; len/addr/data held entry.
module mem_wbuf
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              b_write,
  input  logic [2:0]        b_length,
  input  logic [ADDR_W-1:0] b_addr,
  input  word_t             b_data,
  input  logic              clear,
  output logic              b_busy,
  output logic [2:0]        len,
  output logic [ADDR_W-1:0] addr,
  output word_t             data
);
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      b_busy <= 1'b0;
      len    <= '0;
      addr   <= '0;
      data   <= '0;
    end else if (clear) begin
      b_busy <= 1'b0;
    end else if (b_write && !b_busy) begin
      b_busy <= 1'b1;
      len    <= eff_len(b_length);
      addr   <= b_addr;
      data   <= b_data;
    end
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-wide RAM/IO port owner arbitrating write buffer > D-cache read > I-cache read.
// Ports: clock/reset (async, active-low); i_* I-cache word reads; d_* D-cache reads of 1/2/4 bytes;
// b_* write buffer push and b_busy; mem_din/io_full from RAM/IO; mem_a/mem_dout/mem_wr byte beats.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int IO_BIT = IO_BIT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_busy,
  output logic              i_ready,
  output word_t             i_data,
  input  logic              d_read,
  input  logic [2:0]        d_length,
  input  logic              d_signed,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_busy,
  output logic              d_ready,
  output word_t             d_data,
  input  logic              b_write,
  input  logic [2:0]        b_length,
  input  logic [ADDR_W-1:0] b_addr,
  input  word_t             b_data,
  output logic              b_busy,
  input  byte_t             mem_din,
  input  logic              io_full,
  output byte_t             mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);
  state_t state, state_nxt;
  logic [2:0] cnt, len, wb_len;
  logic [ADDR_W-1:0] base, wb_addr;
  logic sel_d, sgn, stall, last_wr, beat;
  word_t acc, wb_data;
  assign stall   = base[IO_BIT] && io_full;
  assign last_wr = state == WR && !stall && cnt == len - 3'd1;
  mem_wbuf #(.ADDR_W(ADDR_W)) u_wbuf (
    .clock   (clock),
    .reset   (reset),
    .b_write (b_write),
    .b_length(b_length),
    .b_addr  (b_addr),
    .b_data  (b_data),
    .clear   (last_wr),
    .b_busy  (b_busy),
    .len     (wb_len),
    .addr    (wb_addr),
    .data    (wb_data)
  );
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = b_busy ? WR : (d_read || i_read) ? RD : IDLE;
      RD:      state_nxt = cnt == len ? DONE : RD;
      WR:      state_nxt = last_wr ? IDLE : WR;
      default: state_nxt = IDLE;
    endcase
  end
  // RD runs cnt = 0..len: addresses go out while cnt < len, each byte lands one cycle later.
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      len   <= '0;
      base  <= '0;
      sel_d <= 1'b0;
      sgn   <= 1'b0;
      acc   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        cnt <= '0;
        if (b_busy) begin
          base <= wb_addr;
          len  <= wb_len;
        end else if (d_read) begin
          base  <= d_addr;
          len   <= eff_len(d_length);
          sel_d <= 1'b1;
          sgn   <= d_signed;
        end else if (i_read) begin
          base  <= i_addr;
          len   <= LEN_W;
          sel_d <= 1'b0;
          sgn   <= 1'b0;
        end
      end else if (state == RD) begin
        cnt <= cnt + 3'd1;
        if (cnt != 3'd0) acc <= {mem_din, acc[31:8]};
      end else if (state == WR && !stall) begin
        cnt <= cnt + 3'd1;
      end
    end
  assign beat     = state == WR || (state == RD && cnt < len);
  assign mem_a    = beat ? base + ADDR_W'(cnt) : '0;
  assign mem_dout = state == WR ? wb_data[{cnt[1:0], 3'b000} +: 8] : '0;
  assign mem_wr   = state == WR && !stall;
  assign i_busy   = (state == RD || state == DONE) && !sel_d;
  assign d_busy   = (state == RD || state == DONE) && sel_d;
  assign i_ready  = state == DONE && !sel_d;
  assign d_ready  = state == DONE && sel_d;
  assign i_data   = i_ready ? acc : '0;
  assign d_data   = d_ready ? extend(acc, len, sgn) : '0;
endmodule
